univ_shift_engine: RTL and testbench

UNIV_SHIFT_ENGINE -- requirements
Module: univ_shift_engine

---
 rtl/univ_shift_engine.sv | 169 ++++++++++++++++
 tb/tb_univ_shift_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_engine.sv
// univ_shift_engine: N-bit universal shift/rotate register.
// Supported operations: NOP, LOAD, CLR, SLL, SRL, SRA, ROL and ROR.
// Default build: an iterative engine that shifts one bit per cycle while o_busy is high.
// With UNIV_SHIFT_ENGINE_BARREL_EN defined, every opcode finishes at the accept edge.
// That build uses a combinational network that produces the same bits as the iterative engine.
module univ_shift_engine #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [2:0]    i_op,
    input  logic [AW-1:0] i_amt,
    input  logic          i_sin,
    input  logic [N-1:0]  i_d,
    output logic [N-1:0]  o_q,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_sout
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    // One 1-bit step. The result is packed as {bit shifted out, new register value}.
    function automatic logic [N:0] f_step(input logic [N-1:0] q, input logic [2:0] op,
                                          input logic sin);
        case (op)
            OP_SLL:  f_step = {q[N-1], q[N-2:0], sin};
            OP_SRL:  f_step = {q[0], sin, q[N-1:1]};
            OP_SRA:  f_step = {q[0], q[N-1], q[N-1:1]};
            OP_ROL:  f_step = {q[N-1], q[N-2:0], q[N-1]};
            OP_ROR:  f_step = {q[0], q[0], q[N-1:1]};
            default: f_step = {1'b0, q};
        endcase
    endfunction

    // True for the five shift and rotate opcodes.
    function automatic logic f_is_shift(input logic [2:0] op);
        f_is_shift = (op >= OP_SLL) && (op <= OP_ROR);
    endfunction

    logic [N-1:0] r_q;
    logic         r_sout;
    logic         r_done;

`ifdef UNIV_SHIFT_ENGINE_BARREL_EN

    logic [N-1:0] w_bar_q;
    logic         w_bar_sout;
    logic [N:0]   w_bar_tmp;

    // Unroll one step per possible amount, gated by i_amt, so the bits match the iterative engine.
    always_comb begin
        w_bar_q    = r_q;
        w_bar_sout = r_sout;
        w_bar_tmp  = {r_sout, r_q};
        for (int i = 0; i < (1 << AW); i++) begin
            if (i < int'(i_amt)) begin
                w_bar_tmp  = f_step(w_bar_q, i_op, i_sin);
                w_bar_q    = w_bar_tmp[N-1:0];
                w_bar_sout = w_bar_tmp[N];
            end else begin
                w_bar_q    = w_bar_q;
                w_bar_sout = w_bar_sout;
            end
        end
    end

    // Register update: every accepted command completes at the accept edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q    <= {N{1'b0}};
            r_sout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= i_start;
            if (i_start) begin
                case (i_op)
                    OP_LOAD: r_q <= i_d;
                    OP_CLR:  r_q <= {N{1'b0}};
                    OP_NOP:  r_q <= r_q;
                    default: begin
                        r_q    <= w_bar_q;
                        r_sout <= w_bar_sout;
                    end
                endcase
            end
        end
    end

    assign o_busy = 1'b0;

`else

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [2:0]    r_op;
    logic          r_sin;
    logic [AW-1:0] r_cnt;
    logic [N:0]    w_step;

    // Next single-bit step of the operation in progress.
    always_comb begin
        w_step = f_step(r_q, r_op, r_sin);
    end

    // FSM and datapath: accept commands in IDLE, shift one bit per cycle in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_q     <= {N{1'b0}};
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= OP_NOP;
            r_sin   <= 1'b0;
            r_cnt   <= {AW{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (f_is_shift(i_op) && (i_amt != {AW{1'b0}})) begin
                            r_op    <= i_op;
                            r_sin   <= i_sin;
                            r_cnt   <= i_amt;
                            r_state <= ST_RUN;
                        end else begin
                            r_done <= 1'b1;
                            if (i_op == OP_LOAD) begin
                                r_q <= i_d;
                            end else if (i_op == OP_CLR) begin
                                r_q <= {N{1'b0}};
                            end
                        end
                    end
                end
                ST_RUN: begin
                    r_q    <= w_step[N-1:0];
                    r_sout <= w_step[N];
                    r_cnt  <= r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == ST_RUN);

`endif

    assign o_q    = r_q;
    assign o_sout = r_sout;
    assign o_done = r_done;

endmodule

// File: tb/tb_univ_shift_engine.sv
// Self-checking bench for univ_shift_engine (N=8, AW=3).
// Directed cases are followed by random commands, checked against an arithmetic reference model.
module tb_univ_shift_engine;

`ifdef UNIV_SHIFT_ENGINE_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [2:0] i_op;
    logic [2:0] i_amt;
    logic       i_sin;
    logic [7:0] i_d;
    logic [7:0] o_q;
    logic       o_busy;
    logic       o_done;
    logic       o_sout;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0] m_q;
    logic       m_sout;

    univ_shift_engine #(.N(8), .AW(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_amt(i_amt),
        .i_sin(i_sin), .i_d(i_d), .o_q(o_q), .o_busy(o_busy), .o_done(o_done), .o_sout(o_sout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-operation reference: returns {sout, q} after applying op with amount k in one go.
    function automatic logic [8:0] model(input logic [2:0] op, input int k, input logic [7:0] q,
                                         input logic sin, input logic sout, input logic [7:0] d);
        logic [15:0] t;
        logic [7:0]  res;
        logic        so;
        int          r;
        res = q;
        so  = sout;
        r   = k % 8;
        case (op)
            3'b001: res = d;
            3'b111: res = 8'h00;
            3'b010: if (k > 0) begin
                t   = {8'h00, q} << k;
                res = t[7:0] | (sin ? (8'hFF >> (8 - k)) : 8'h00);
                so  = t[8];
            end
            3'b011: if (k > 0) begin
                t   = {q, 8'h00} >> k;
                res = t[15:8] | (sin ? ~(8'hFF >> k) : 8'h00);
                so  = t[7];
            end
            3'b100: if (k > 0) begin
                t   = $signed({q, 8'h00}) >>> k;
                res = t[15:8];
                so  = t[7];
            end
            3'b101: if (k > 0) begin
                t   = {q, q} << r;
                res = t[15:8];
                so  = res[0];
            end
            3'b110: if (k > 0) begin
                t   = {q, q} >> r;
                res = t[7:0];
                so  = res[7];
            end
            default: res = q;
        endcase
        return {so, res};
    endfunction

    // Issue one command at a falling edge, then check latency, result and the done pulse.
    task automatic do_cmd(input string tag, input logic [2:0] op, input int amt,
                          input logic sin, input logic [7:0] d);
        logic [8:0] e;
        int nb;
        int exp_nb;
        e      = model(op, amt, m_q, sin, m_sout, d);
        exp_nb = (!BARREL && op >= 3'd2 && op <= 3'd6) ? amt : 0;
        i_op = op; i_amt = 3'(amt); i_sin = sin; i_d = d; i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        nb = 0;
        while (o_busy && nb < 40) begin
            nb++;
            @(negedge i_clk);
        end
        check({tag, "_busy_cycles"}, nb, exp_nb);
        check({tag, "_done"}, o_done, 1'b1);
        check({tag, "_q"}, o_q, e[7:0]);
        check({tag, "_sout"}, o_sout, e[8]);
        m_q = e[7:0];
        m_sout = e[8];
        @(negedge i_clk);
        check({tag, "_done_clears"}, o_done, 1'b0);
    endtask

    initial begin
        int nb;
        int dones;
        logic [8:0] e;
        i_rst = 1'b1; i_start = 1'b0; i_op = 3'b000; i_amt = 3'd0; i_sin = 1'b0; i_d = 8'h00;
        m_q = 8'h00; m_sout = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_q", o_q, 8'h00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_sout", o_sout, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Directed examples
        do_cmd("load_a5", 3'b001, 0, 1'b0, 8'hA5);
        do_cmd("sll3", 3'b010, 3, 1'b1, 8'h00);
        check("sll3_literal", o_q, 8'h2F);
        do_cmd("load_90", 3'b001, 0, 1'b0, 8'h90);
        do_cmd("sra2", 3'b100, 2, 1'b0, 8'h00);
        check("sra2_literal", o_q, 8'hE4);
        do_cmd("load_81", 3'b001, 0, 1'b0, 8'h81);
        do_cmd("ror1", 3'b110, 1, 1'b0, 8'h00);
        do_cmd("load_01", 3'b001, 0, 1'b0, 8'h01);
        do_cmd("rol7", 3'b101, 7, 1'b0, 8'h00);
        check("rol7_literal", o_q, 8'h80);
        do_cmd("srl0", 3'b011, 0, 1'b1, 8'h00);
        do_cmd("clr", 3'b111, 0, 1'b0, 8'h00);
        do_cmd("nop", 3'b000, 0, 1'b0, 8'h00);

        // SRL by 5 with a LOAD strobe during the run: the LOAD must be ignored
        do_cmd("load_3c", 3'b001, 0, 1'b0, 8'h3C);
        e = model(3'b011, 5, m_q, 1'b0, m_sout, 8'h00);
        i_op = 3'b011; i_amt = 3'd5; i_sin = 1'b0; i_start = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_start = 1'b0;
        nb = 0;
        while (o_busy && nb < 40) begin
            nb++;
            if (nb == 2) begin
                i_op = 3'b001; i_d = 8'hFF; i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
        check("midrun_busy_cycles", nb, BARREL ? 0 : 5);
        check("midrun_q", o_q, e[7:0]);
        check("midrun_sout", o_sout, e[8]);
        m_q = e[7:0]; m_sout = e[8];
        @(negedge i_clk);
        check("midrun_no_late_load", o_q, e[7:0]);

        // Reset during the second RUN cycle of SRL by 6 aborts without a done pulse
        do_cmd("load_ff", 3'b001, 0, 1'b0, 8'hFF);
        i_op = 3'b011; i_amt = 3'd6; i_sin = 1'b0; i_start = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("abort_q", o_q, 8'h00);
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        check("abort_sout", o_sout, 1'b0);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_done) dones++;
        end
        check("abort_no_done", dones, 0);
        m_q = 8'h00; m_sout = 1'b0;

        // Random commands against the reference model
        for (int n = 0; n < 80; n++) begin
            do_cmd("rand", 3'($urandom_range(0, 7)), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
